axi4_burst_write_master: RTL and testbench

//  DMA write engine, successor to Write_Master: drains a FWFT FIFO into AXI4 memory with INCR bursts.

---
 rtl/dma_axi_pkg.sv | 33 +++
 rtl/wm_burst_queue.sv | 73 +++++++
 rtl/axi4_burst_write_master.sv | 249 ++++++++++++++++++++++++
 tb/tb_axi4_burst_write_master.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_axi_pkg.sv
// ----------------------------------------------------------------------------
// dma_axi_pkg
// Shared AXI4 constants and the control FSM encoding for the DMA burst write
// master (axi4_burst_write_master) and its burst-length queue.
// ----------------------------------------------------------------------------
package dma_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Reported on o_err_resp when the start address or length is not beat aligned.
    localparam logic [1:0] ERR_MISALIGNED = 2'b11;

    localparam int AXI_4KB = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RUN,
        ST_DONE
    } wm_state_t;

    // EXOKAY is not a legal answer to a non-exclusive write, so anything
    // other than OKAY is treated as a failed burst.
    function automatic logic is_error_resp(input logic [1:0] resp);
        return (resp == RESP_EXOKAY) || (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/wm_burst_queue.sv
// ----------------------------------------------------------------------------
// wm_burst_queue
// Small synchronous FIFO carrying awlen of bursts whose AW handshake has
// completed but whose W beats have not yet started. Head word is visible on
// pop_data while not empty (first-word fall-through).
// Ports:
//   clk, reset_n        clock, async active-low reset (clears pointers/count)
//   push, push_data     write one entry (ignored when full)
//   pop                 drop the head entry (ignored when empty)
//   pop_data            current head entry
//   full, empty         occupancy flags
// ----------------------------------------------------------------------------
module wm_burst_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi4_burst_write_master.sv
// ----------------------------------------------------------------------------
// axi4_burst_write_master
// DMA write engine: drains a FWFT data FIFO into AXI4 memory using INCR
// bursts that never cross a 4KB boundary, with up to C_MAX_OUTSTANDING
// write addresses in flight and sticky error reporting from BRESP.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   i_start/i_dst_addr/i_total_len  transfer request (start ignored while busy)
//   o_busy, o_write_done         status; done is a one-cycle pulse
//   o_error, o_err_resp          sticky error flag and first bad response
//                                (2'b11 for a misaligned request)
//   i_fifo_empty, i_w_data       FWFT FIFO head; o_fifo_rd_en pops it
//   m_axi_aw*/m_axi_w*/m_axi_b*  AXI4 write address, data, response channels
// ----------------------------------------------------------------------------
module axi4_burst_write_master
    import dma_axi_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_MAX_BURST        = 16,
    parameter int C_MAX_OUTSTANDING  = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            i_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_dst_addr,
    input  logic [31:0]                     i_total_len,
    output logic                            o_busy,
    output logic                            o_write_done,
    output logic                            o_error,
    output logic [1:0]                      o_err_resp,
    input  logic                            i_fifo_empty,
    output logic                            o_fifo_rd_en,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_w_data,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic [2:0]                      m_axi_awsize,
    output logic [1:0]                      m_axi_awburst,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wlast,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready
);

    localparam int         BPB      = C_M_AXI_DATA_WIDTH / 8;
    localparam int         LSB      = $clog2(BPB);
    localparam int         OUT_W    = $clog2(C_MAX_OUTSTANDING) + 1;
    localparam logic [2:0] AXI_SIZE = 3'(LSB);

    wm_state_t                     state;
    wm_state_t                     state_next;

    logic [C_M_AXI_ADDR_WIDTH-1:0] dst_addr_r;
    logic [31:0]                   total_len_r;
    logic [C_M_AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [31:0]                   bytes_to_issue;
    logic [OUT_W-1:0]              outstanding;

    logic                          w_active;
    logic [7:0]                    w_len;
    logic [7:0]                    w_cnt;

    logic                          q_pop;
    logic [7:0]                    q_head;
    logic                          q_full;
    logic                          q_empty;

    logic                          aw_hs;
    logic                          w_hs;
    logic                          b_hs;
    logic                          misaligned;
    logic                          run_finished;

    logic [31:0]                   bytes_beats;
    logic [12:0]                   bound_bytes;
    logic [12:0]                   bound_beats;
    logic [8:0]                    beats;
    logic [31:0]                   burst_bytes;

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;
    assign b_hs  = m_axi_bvalid & m_axi_bready;

    assign misaligned   = (dst_addr_r[LSB-1:0] != '0) || (total_len_r[LSB-1:0] != '0);
    assign run_finished = (bytes_to_issue == '0) && q_empty && !w_active && (outstanding == '0);

    // Burst size: limited by what is left, by the burst cap, and by the
    // distance to the next 4KB page so no burst straddles a page.
    assign bytes_beats = bytes_to_issue >> LSB;
    assign bound_bytes = 13'(AXI_4KB) - {1'b0, aw_addr[11:0]};
    assign bound_beats = bound_bytes >> LSB;

    always_comb begin
        beats = 9'(C_MAX_BURST);
        if (bytes_beats < 32'(beats)) begin
            beats = bytes_beats[8:0];
        end
        if (bound_beats < 13'(beats)) begin
            beats = bound_beats[8:0];
        end
    end

    assign burst_bytes = {23'd0, beats} << LSB;

    // ---------------- control FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- control FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (i_start) state_next = ST_CHECK;
            ST_CHECK: state_next = ((total_len_r == '0) || misaligned) ? ST_DONE : ST_RUN;
            ST_RUN:   if (run_finished) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ---------------- control FSM: outputs ----------------
    always_comb begin
        o_busy        = (state != ST_IDLE);
        o_write_done  = (state == ST_DONE);
        m_axi_bready  = (state == ST_RUN);
        // Depends only on registers, and none of the terms can fall before
        // the handshake, so awvalid/awaddr/awlen hold until awready.
        m_axi_awvalid = (state == ST_RUN) && (bytes_to_issue != '0) &&
                        (outstanding < OUT_W'(C_MAX_OUTSTANDING)) && !q_full;
    end

    assign m_axi_awaddr  = aw_addr;
    assign m_axi_awlen   = m_axi_awvalid ? 8'(beats - 9'd1) : 8'd0;
    assign m_axi_awsize  = AXI_SIZE;
    assign m_axi_awburst = AXI_BURST_INCR;

    assign m_axi_wvalid  = w_active & ~i_fifo_empty;
    assign m_axi_wlast   = w_active && (w_cnt == w_len);
    assign m_axi_wdata   = m_axi_wvalid ? i_w_data : '0;
    assign m_axi_wstrb   = '1;
    assign o_fifo_rd_en  = w_hs;

    // ---------------- request capture, AW engine, error reporting ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dst_addr_r     <= '0;
            total_len_r    <= '0;
            aw_addr        <= '0;
            bytes_to_issue <= '0;
            o_error        <= 1'b0;
            o_err_resp     <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        dst_addr_r  <= i_dst_addr;
                        total_len_r <= i_total_len;
                        o_error     <= 1'b0;
                        o_err_resp  <= 2'b00;
                    end
                end
                ST_CHECK: begin
                    aw_addr <= dst_addr_r;
                    if ((total_len_r != '0) && misaligned) begin
                        o_error        <= 1'b1;
                        o_err_resp     <= ERR_MISALIGNED;
                        bytes_to_issue <= '0;
                    end else begin
                        bytes_to_issue <= total_len_r;
                    end
                end
                default: begin
                    if (aw_hs) begin
                        aw_addr        <= aw_addr + C_M_AXI_ADDR_WIDTH'(burst_bytes);
                        bytes_to_issue <= bytes_to_issue - burst_bytes;
                    end
                    if (b_hs && is_error_resp(m_axi_bresp) && !o_error) begin
                        o_error    <= 1'b1;
                        o_err_resp <= m_axi_bresp;
                    end
                end
            endcase
        end
    end

    // ---------------- outstanding AW counter ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else begin
            case ({aw_hs, b_hs})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // ---------------- W engine ----------------
    // A burst is taken from the queue only when no burst is active, so W
    // beats can never run ahead of their AW handshake.
    assign q_pop = ~w_active & ~q_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_active <= 1'b0;
            w_len    <= 8'd0;
            w_cnt    <= 8'd0;
        end else if (!w_active) begin
            if (!q_empty) begin
                w_active <= 1'b1;
                w_len    <= q_head;
                w_cnt    <= 8'd0;
            end
        end else if (w_hs) begin
            if (w_cnt == w_len) begin
                w_active <= 1'b0;
            end else begin
                w_cnt <= w_cnt + 8'd1;
            end
        end
    end

    wm_burst_queue #(
        .DEPTH (C_MAX_OUTSTANDING),
        .WIDTH (8)
    ) u_burst_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (aw_hs),
        .push_data (m_axi_awlen),
        .pop       (q_pop),
        .pop_data  (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

endmodule

// File: tb/tb_axi4_burst_write_master.sv
// ----------------------------------------------------------------------------
// tb_axi4_burst_write_master
// Scoreboard bench: each transfer request is expanded by a byte-level model
// into expected AW bursts and W beats; a single monitor pops and compares on
// every AXI handshake. A slave/FIFO process supplies randomized ready, data
// availability and delayed B responses.
// ----------------------------------------------------------------------------
module tb_axi4_burst_write_master;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BPB  = DW / 8;
    localparam int MAXB = 16;
    localparam int MAXO = 4;

    logic            clk;
    logic            reset_n;
    logic            i_start;
    logic [AW-1:0]   i_dst_addr;
    logic [31:0]     i_total_len;
    logic            o_busy;
    logic            o_write_done;
    logic            o_error;
    logic [1:0]      o_err_resp;
    logic            i_fifo_empty;
    logic            o_fifo_rd_en;
    logic [DW-1:0]   i_w_data;
    logic [AW-1:0]   m_axi_awaddr;
    logic [7:0]      m_axi_awlen;
    logic [2:0]      m_axi_awsize;
    logic [1:0]      m_axi_awburst;
    logic            m_axi_awvalid;
    logic            m_axi_awready;
    logic [DW-1:0]   m_axi_wdata;
    logic [BPB-1:0]  m_axi_wstrb;
    logic            m_axi_wlast;
    logic            m_axi_wvalid;
    logic            m_axi_wready;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_bvalid;
    logic            m_axi_bready;

    axi4_burst_write_master #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .C_MAX_BURST        (MAXB),
        .C_MAX_OUTSTANDING  (MAXO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_start       (i_start),
        .i_dst_addr    (i_dst_addr),
        .i_total_len   (i_total_len),
        .o_busy        (o_busy),
        .o_write_done  (o_write_done),
        .o_error       (o_error),
        .o_err_resp    (o_err_resp),
        .i_fifo_empty  (i_fifo_empty),
        .o_fifo_rd_en  (o_fifo_rd_en),
        .i_w_data      (i_w_data),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef struct { logic [31:0] addr; logic [7:0] len; } aw_exp_t;
    typedef struct { logic [31:0] data; logic last; } w_exp_t;

    aw_exp_t exp_aw[$];
    w_exp_t  exp_w[$];

    int n_cmp = 0;
    int n_err = 0;

    int aw_cnt, w_beats, b_cnt, done_cnt, aw_at_first_b, first_aw_cyc, start_cyc;
    bit first_aw_seen;

    // ---------------- slave / FIFO configuration ----------------
    int          aw_pct   = 100;
    int          w_pct    = 100;
    int          fill_pct = 100;
    int          b_delay  = 0;
    int          err_burst = -1;
    int          b_idx    = 0;
    int          fifo_avail = 0;
    bit          fifo_hold = 0;
    logic [31:0] fifo_word = 32'hA000_0000;
    int          b_due[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-level reference: walk the transfer, cutting bursts at the burst
    // cap and at every 4KB page edge; data is the FIFO counter sequence.
    task automatic model_xfer(input logic [31:0] addr, input logic [31:0] len, output int nb);
        longint      a, rem, beats, to_page;
        logic [31:0] word;
        aw_exp_t     ea;
        w_exp_t      ew;
        nb   = 0;
        word = 32'hA000_0000;
        if (len == 0 || (addr % BPB) != 0 || (len % BPB) != 0) return;
        a   = longint'(addr);
        rem = longint'(len);
        while (rem > 0) begin
            to_page = 4096 - (a % 4096);
            beats   = rem / BPB;
            if (beats > MAXB) beats = MAXB;
            if (to_page / BPB < beats) beats = to_page / BPB;
            ea.addr = a[31:0];
            ea.len  = 8'(beats - 1);
            exp_aw.push_back(ea);
            for (longint i = 0; i < beats; i++) begin
                ew.data = word;
                ew.last = (i == beats - 1);
                exp_w.push_back(ew);
                word++;
            end
            a   = (a + beats * BPB) % 64'h1_0000_0000;
            rem = rem - beats * BPB;
            nb++;
        end
    endtask

    // ---------------- monitor ----------------
    aw_exp_t m_ea;
    w_exp_t  m_ew;

    always @(negedge clk) begin
        if (reset_n) begin
            if (m_axi_awvalid && !first_aw_seen) begin
                first_aw_seen = 1;
                first_aw_cyc  = cyc;
            end
            if (m_axi_awvalid && m_axi_awready) begin
                aw_cnt++;
                n_cmp++;
                if (exp_aw.size() == 0) begin
                    n_err++;
                    $display("FAIL aw_unexpected: got awaddr 0x%0h awlen %0d, expected no burst", m_axi_awaddr, m_axi_awlen);
                end else begin
                    m_ea = exp_aw.pop_front();
                    check("awaddr", 64'(m_axi_awaddr), 64'(m_ea.addr));
                    check("awlen", 64'(m_axi_awlen), 64'(m_ea.len));
                    check("awsize", 64'(m_axi_awsize), 64'd2);
                    check("awburst", 64'(m_axi_awburst), 64'd1);
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_beats++;
                n_cmp++;
                if (exp_w.size() == 0) begin
                    n_err++;
                    $display("FAIL w_unexpected: got wdata 0x%0h, expected no beat", m_axi_wdata);
                end else begin
                    m_ew = exp_w.pop_front();
                    check("wdata", 64'(m_axi_wdata), 64'(m_ew.data));
                    check("wlast", 64'(m_axi_wlast), 64'(m_ew.last));
                    check("wstrb", 64'(m_axi_wstrb), 64'hF);
                    check("rd_en_on_beat", 64'(o_fifo_rd_en), 64'd1);
                end
            end else if (o_fifo_rd_en) begin
                check("rd_en_without_beat", 64'(o_fifo_rd_en), 64'd0);
            end
            if (m_axi_bvalid && m_axi_bready) begin
                if (b_cnt == 0) aw_at_first_b = aw_cnt;
                b_cnt++;
            end
            if (o_write_done) done_cnt++;
        end
    end

    // ---------------- AXI slave and FIFO model ----------------
    initial begin
        bit aw_s, w_s, wl_s, b_s;
        forever begin
            @(negedge clk);
            aw_s = m_axi_awvalid & m_axi_awready;
            w_s  = m_axi_wvalid & m_axi_wready;
            wl_s = w_s & m_axi_wlast;
            b_s  = m_axi_bvalid & m_axi_bready;
            @(posedge clk);
            #1;
            if (w_s) begin
                fifo_word++;
                if (fifo_avail > 0) fifo_avail--;
            end
            if (wl_s) b_due.push_back(cyc + b_delay);
            if (!fifo_hold && fifo_avail < 1000 && $urandom_range(99) < fill_pct) fifo_avail++;
            if (b_s) begin
                m_axi_bvalid = 1'b0;
                m_axi_bresp  = 2'b00;
                b_idx++;
            end
            if (!m_axi_bvalid && b_due.size() > 0 && b_due[0] <= cyc) begin
                void'(b_due.pop_front());
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
            end
            m_axi_awready = ($urandom_range(99) < aw_pct);
            m_axi_wready  = ($urandom_range(99) < w_pct);
            i_fifo_empty  = (fifo_avail == 0);
            i_w_data      = fifo_word;
        end
    end

    task automatic run_xfer(input string tag, input logic [31:0] addr, input logic [31:0] len,
                            input int err_b, input bit chk_lat);
        int         nb;
        bit         got_done;
        logic       exp_err;
        logic [1:0] exp_resp;
        err_burst     = err_b;
        b_idx         = 0;
        fifo_word     = 32'hA000_0000;
        aw_cnt        = 0;
        w_beats       = 0;
        b_cnt         = 0;
        done_cnt      = 0;
        first_aw_seen = 0;
        aw_at_first_b = -1;
        model_xfer(addr, len, nb);
        if (len != 0 && ((addr % BPB) != 0 || (len % BPB) != 0)) begin
            exp_err  = 1'b1;
            exp_resp = 2'b11;
        end else if (err_b >= 0 && err_b < nb) begin
            exp_err  = 1'b1;
            exp_resp = 2'b10;
        end else begin
            exp_err  = 1'b0;
            exp_resp = 2'b00;
        end
        @(posedge clk);
        #1;
        i_start     = 1'b1;
        i_dst_addr  = addr;
        i_total_len = len;
        start_cyc   = cyc;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        got_done = 0;
        for (int i = 0; i < 6000 && !got_done; i++) begin
            @(negedge clk);
            if (o_write_done) got_done = 1;
        end
        check({tag, "_done_seen"}, 64'(got_done), 64'd1);
        check({tag, "_busy_at_done"}, 64'(o_busy), 64'd1);
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_busy_after"}, 64'(o_busy), 64'd0);
        check({tag, "_aw_count"}, 64'(aw_cnt), 64'(nb));
        check({tag, "_b_count"}, 64'(b_cnt), 64'(nb));
        check({tag, "_aw_left"}, 64'(exp_aw.size()), 64'd0);
        check({tag, "_w_left"}, 64'(exp_w.size()), 64'd0);
        check({tag, "_error"}, 64'(o_error), 64'(exp_err));
        check({tag, "_err_resp"}, 64'(o_err_resp), 64'(exp_resp));
        if (chk_lat) check({tag, "_aw_latency"}, 64'(first_aw_cyc - start_cyc), 64'd2);
        exp_aw.delete();
        exp_w.delete();
    endtask

    task automatic gap_watch();
        for (int i = 0; i < 300 && w_beats < 4; i++) @(negedge clk);
        check("gap_reached", 64'(w_beats >= 4), 64'd1);
        repeat (20) begin
            @(negedge clk);
            check("gap_wvalid", 64'(m_axi_wvalid), 64'd0);
            check("gap_rd_en", 64'(o_fifo_rd_en), 64'd0);
        end
        fifo_hold = 0;
    endtask

    task automatic set_slave(input int awp, input int wp, input int fp, input int bd);
        aw_pct   = awp;
        w_pct    = wp;
        fill_pct = fp;
        b_delay  = bd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nb;
        logic [31:0] ra, rl;
        reset_n       = 1'b0;
        i_start       = 1'b0;
        i_dst_addr    = '0;
        i_total_len   = '0;
        i_fifo_empty  = 1'b1;
        i_w_data      = '0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_bvalid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        check("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
        check("rst_bready", 64'(m_axi_bready), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_write_done), 64'd0);
        check("rst_error", 64'(o_error), 64'd0);
        check("rst_awsize", 64'(m_axi_awsize), 64'd2);
        check("rst_awburst", 64'(m_axi_awburst), 64'd1);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        set_slave(100, 100, 100, 0);
        run_xfer("single64", 32'hC000_0000, 32'd64, -1, 1);
        run_xfer("two128", 32'hC000_1000, 32'd128, -1, 0);
        run_xfer("split4k", 32'hC000_0FF0, 32'd64, -1, 0);

        fifo_avail = 4;
        fifo_hold  = 1;
        fork
            run_xfer("fifo_gap", 32'hC000_2000, 32'd64, -1, 0);
            gap_watch();
        join

        set_slave(100, 100, 100, 3);
        run_xfer("bresp_err", 32'hC000_3000, 32'd256, 1, 0);
        run_xfer("len6", 32'hC000_0000, 32'd6, -1, 0);
        run_xfer("addr_mis", 32'hC000_0002, 32'd64, -1, 0);
        run_xfer("len0", 32'hC000_0000, 32'd0, -1, 0);

        set_slave(100, 100, 100, 20);
        run_xfer("outstanding", 32'hC000_4000, 32'd512, -1, 0);
        check("aw_before_first_b", 64'(aw_at_first_b), 64'(MAXO));

        for (int t = 0; t < 8; t++) begin
            set_slave($urandom_range(40, 100), $urandom_range(40, 100),
                      $urandom_range(30, 100), $urandom_range(0, 12));
            ra = 32'hC000_0000 + 32'($urandom_range(0, 4095)) * 4;
            rl = 32'($urandom_range(1, 80)) * 4;
            run_xfer("random", ra, rl, (t % 3 == 0) ? $urandom_range(0, 3) : -1, 0);
        end

        // Reset in the middle of a transfer, then a fresh transfer.
        set_slave(100, 100, 100, 0);
        fifo_word = 32'hA000_0000;
        model_xfer(32'hC000_5000, 32'd512, nb);
        @(posedge clk);
        #1;
        i_start     = 1'b1;
        i_dst_addr  = 32'hC000_5000;
        i_total_len = 32'd512;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_awvalid", 64'(m_axi_awvalid), 64'd0);
        check("midrst_awaddr", 64'(m_axi_awaddr), 64'd0);
        check("midrst_awlen", 64'(m_axi_awlen), 64'd0);
        check("midrst_wvalid", 64'(m_axi_wvalid), 64'd0);
        check("midrst_wlast", 64'(m_axi_wlast), 64'd0);
        check("midrst_rd_en", 64'(o_fifo_rd_en), 64'd0);
        check("midrst_bready", 64'(m_axi_bready), 64'd0);
        check("midrst_busy", 64'(o_busy), 64'd0);
        check("midrst_done", 64'(o_write_done), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #3;
        exp_aw.delete();
        exp_w.delete();
        b_due.delete();
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        done_cnt     = 0;
        reset_n      = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        run_xfer("after_rst", 32'hC000_6000, 32'd64, -1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
